// File: rtl/spi_sensor_pkg.sv
`default_nettype none
// ============================================================================
// spi_sensor_pkg : shared defaults, FSM encoding and frame builder
// Revision: 1.0
// ============================================================================
package spi_sensor_pkg;

    localparam int DEF_FRAME_BITS  = 16;
    localparam int DEF_DATA_BITS   = 8;
    localparam int DEF_DATA_LSB    = 4;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Zero-padded frame with the payload placed at frame bit 'lsb' upward.
    function automatic logic [DEF_FRAME_BITS-1:0] build_frame(
        input logic [DEF_DATA_BITS-1:0] payload,
        input int                       lsb
    );
        return DEF_FRAME_BITS'(payload) << lsb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_in_sync.sv
`default_nettype none
// ============================================================================
// spi_in_sync : multi-stage input synchronizer with rise/fall edge detect
// Revision: 1.0
// ============================================================================
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Idle-high reset so a line sitting high at reset release shows no edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_sensor_slave.sv
`default_nettype none
// ============================================================================
// spi_sensor_slave : SPI transmit-side sensor emulator, 16-bit framed sample
// Revision: 1.0
// ============================================================================
module spi_sensor_slave
    import spi_sensor_pkg::*;
#(
    parameter int FRAME_BITS  = DEF_FRAME_BITS,
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int DATA_LSB    = DEF_DATA_LSB,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic                 ss,
    input  logic                 sclk,
    output logic                 miso,
    output logic                 miso_oe,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic                 underrun
);

    localparam int                 c_cnt_w    = $clog2(FRAME_BITS + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(FRAME_BITS - 1);

    logic w_ss_rise, w_ss_fall, w_sclk_rise, w_sclk_fall, w_accept;

    state_e                 state_q, state_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [c_cnt_w-1:0]     bit_cnt_q, bit_cnt_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0]   hold_data_q, hold_data_d;
    logic [DATA_BITS-1:0]   last_q, last_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic                   underrun_q, underrun_d;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .clk    (clk),
        .rstn   (rstn),
        .async_i(ss),
        .rise_o (w_ss_rise),
        .fall_o (w_ss_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk    (clk),
        .rstn   (rstn),
        .async_i(sclk),
        .rise_o (w_sclk_rise),
        .fall_o (w_sclk_fall)
    );

    assign w_accept = data_valid & ~hold_full_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        last_d      = last_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        underrun_d  = 1'b0;

        if (w_accept) begin
            hold_full_d = 1'b1;
            hold_data_d = data_in;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    if (hold_full_q) begin
                        shift_d     = build_frame(hold_data_q, DATA_LSB);
                        hold_full_d = 1'b0;
                        last_d      = hold_data_q;
                    end else begin
                        shift_d    = build_frame(last_q, DATA_LSB);
                        underrun_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                // Completion outranks a coincident deselect: no abort then.
                if (w_sclk_rise && bit_cnt_q == c_last_cnt) begin
                    bit_cnt_d = w_ss_rise ? '0 : bit_cnt_q + 1'b1;
                    done_d    = 1'b1;
                    state_d   = w_ss_rise ? ST_IDLE : ST_DONE;
                end else if (w_ss_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    abort_d   = 1'b1;
                end else begin
                    if (w_sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    // The leading fall of the idle-high clock keeps the MSB in place.
                    if (w_sclk_fall && bit_cnt_q != '0) begin
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
            ST_DONE: begin
                if (w_ss_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            last_q      <= '0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            last_q      <= last_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            underrun_q  <= underrun_d;
        end
    end

    assign data_ready  = ~hold_full_q;
    assign miso        = (state_q == ST_SHIFT) & shift_q[FRAME_BITS-1];
    assign miso_oe     = (state_q != ST_IDLE);
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign underrun    = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_sensor_slave.sv
`default_nettype none
// ============================================================================
// tb_spi_sensor_slave : self-checking bench, table vectors plus random frames
// Revision: 1.0
// ============================================================================
module tb_spi_sensor_slave;

    logic       clk = 1'b0;
    logic       rstn, data_valid, data_ready, ss, sclk;
    logic       miso, miso_oe, frame_done, frame_abort, underrun;
    logic [7:0] data_in;

    always #5 clk = ~clk;

    spi_sensor_slave dut (
        .clk        (clk),
        .rstn       (rstn),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .ss         (ss),
        .sclk       (sclk),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .frame_done (frame_done),
        .frame_abort(frame_abort),
        .underrun   (underrun)
    );

    int n_cmp = 0, n_bad = 0;
    int done_cnt = 0, abort_cnt = 0, und_cnt = 0;

    // Pulse counters: a stretched pulse counts more than once.
    always @(negedge clk) begin
        if (frame_done === 1'b1)  done_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
        if (underrun === 1'b1)    und_cnt++;
    end

    // Reference model: one-deep holding slot plus the last payload sent.
    bit         m_full;
    logic [7:0] m_hold, m_last;
    logic [15:0] m_frame;
    bit          m_und;

    logic [31:0] r_got;
    logic        r_oe_mid, r_oe_end, r_miso_end, r_oe_after, r_miso_after, r_ready;
    int          r_done, r_abort, r_und;

    typedef struct {
        bit         load;
        logic [7:0] payload;
        int         nbits;
        logic [15:0] exp_frame;
        bit          exp_und;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic acc;
        acc = data_valid && data_ready;
        @(negedge clk);
        if (acc) begin
            m_full     = 1'b1;
            m_hold     = data_in;
            data_valid = 1'b0;
        end
    endtask

    task automatic load(input logic [7:0] v);
        int k;
        data_in    = v;
        data_valid = 1'b1;
        k = 0;
        while (data_valid && k < 50) begin
            tick();
            k++;
        end
        if (data_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load_timeout: data %h not accepted within 50 cycles", v);
            data_valid = 1'b0;
        end
    endtask

    function automatic void model_start();
        logic [7:0] p;
        if (m_full) begin
            p      = m_hold;
            m_full = 1'b0;
            m_last = m_hold;
            m_und  = 1'b0;
        end else begin
            p     = m_last;
            m_und = 1'b1;
        end
        m_frame = {4'b0000, p, 4'b0000};
    endfunction

    task automatic run_frame(input int nbits);
        int d0, a0, u0;
        d0 = done_cnt; a0 = abort_cnt; u0 = und_cnt;
        model_start();
        r_got = '0;
        ss = 1'b0;
        repeat (6) tick();
        r_oe_mid = miso_oe;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            repeat (8) tick();
            sclk = 1'b1;
            r_got = {r_got[30:0], miso};
            repeat (8) tick();
        end
        repeat (4) tick();
        r_oe_end   = miso_oe;
        r_miso_end = miso;
        ss = 1'b1;
        repeat (6) tick();
        r_oe_after   = miso_oe;
        r_miso_after = miso;
        r_ready      = data_ready;
        r_done  = done_cnt - d0;
        r_abort = abort_cnt - a0;
        r_und   = und_cnt - u0;
    endtask

    task automatic check_frame(input string tag, input int nbits,
                               input logic [15:0] ef, input bit eu);
        logic [31:0] eb;
        bit full;
        full = (nbits >= 16);
        eb = full ? ({16'h0, ef} << (nbits - 16)) : ({16'h0, ef} >> (16 - nbits));
        chk({tag, " bits"},      r_got, eb);
        chk({tag, " done"},      32'(r_done),  full ? 32'd1 : 32'd0);
        chk({tag, " abort"},     32'(r_abort), full ? 32'd0 : 32'd1);
        chk({tag, " underrun"},  32'(r_und),   eu ? 32'd1 : 32'd0);
        chk({tag, " oe_mid"},    r_oe_mid, 1);
        chk({tag, " oe_end"},    r_oe_end, 1);
        if (full) chk({tag, " miso_end"}, r_miso_end, 0);
        chk({tag, " oe_after"},  r_oe_after, 0);
        chk({tag, " miso_after"}, r_miso_after, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 16, 16'h0A50, 1'b0};
        vecs[1] = '{1'b1, 8'h3C, 16, 16'h03C0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 16, 16'h03C0, 1'b1};
        vecs[3] = '{1'b1, 8'h81,  5, 16'h0810, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 16, 16'h0810, 1'b1};
        vecs[5] = '{1'b1, 8'hFF, 16, 16'h0FF0, 1'b0};
        vecs[6] = '{1'b1, 8'h5A, 20, 16'h05A0, 1'b0};
        vecs[7] = '{1'b1, 8'h00, 16, 16'h0000, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 16, 16'h0000, 1'b1};

        m_full = 1'b0; m_hold = '0; m_last = '0;
        rstn = 1'b0; ss = 1'b1; sclk = 1'b1; data_valid = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        chk("reset miso",      miso, 0);
        chk("reset miso_oe",   miso_oe, 0);
        chk("reset data_ready", data_ready, 1);
        chk("reset pulses",    {frame_done, frame_abort, underrun}, 0);
        rstn = 1'b1;
        repeat (3) tick();

        foreach (vecs[i]) begin
            if (vecs[i].load) load(vecs[i].payload);
            run_frame(vecs[i].nbits);
            check_frame($sformatf("vec%0d", i), vecs[i].nbits, vecs[i].exp_frame, vecs[i].exp_und);
            chk($sformatf("vec%0d ready", i), r_ready, 1);
        end

        // Backpressure: second sample waits until the frame start frees the slot.
        load(8'h11);
        chk("hold full ready", data_ready, 0);
        data_in = 8'h22;
        data_valid = 1'b1;
        repeat (3) tick();
        chk("hold offer pending", {data_ready, data_valid}, 2'b01);
        run_frame(16);
        check_frame("hold first", 16, 16'h0110, 1'b0);
        chk("hold refilled ready", r_ready, 0);
        run_frame(16);
        check_frame("hold second", 16, 16'h0220, 1'b0);
        chk("hold drained ready", r_ready, 1);

        // Reset in the middle of a frame while the slot holds a further sample.
        load(8'h7F);
        model_start();
        ss = 1'b0;
        repeat (6) tick();
        load(8'h66);
        for (int i = 0; i < 7; i++) begin
            sclk = 1'b0; repeat (8) tick();
            sclk = 1'b1; repeat (8) tick();
        end
        sclk = 1'b0;
        repeat (4) tick();
        chk("pre-reset miso", miso, 1);
        rstn = 1'b0;
        #1;
        chk("mid-reset miso",      miso, 0);
        chk("mid-reset miso_oe",   miso_oe, 0);
        chk("mid-reset data_ready", data_ready, 1);
        m_full = 1'b0; m_hold = '0; m_last = '0;
        ss = 1'b1; sclk = 1'b1;
        repeat (4) tick();
        rstn = 1'b1;
        repeat (4) tick();
        run_frame(16);
        check_frame("post-reset", 16, 16'h0000, 1'b1);

        for (int it = 0; it < 24; it++) begin
            bit         ld;
            logic [7:0] p;
            int         nb;
            ld = ($urandom_range(0, 9) < 7);
            p  = 8'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15))
                                             : int'($urandom_range(16, 18));
            if (ld) load(p);
            run_frame(nb);
            check_frame($sformatf("rand%0d", it), nb, m_frame, m_und);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
